// File: rtl/dma_rd_desc_arb_pkg.sv
// Shared widths, helpers and descriptor layout for the read-descriptor arbiter.
package dma_rd_desc_arb_pkg;

  // Index width for a port count; never narrower than one bit.
  function automatic int cl_ports(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int m_tag_width(input int s_tag_width, input int ports);
    return s_tag_width + cl_ports(ports);
  endfunction

  function automatic int m_sel_width(input int ram_sel_width, input int ports);
    return ram_sel_width + cl_ports(ports);
  endfunction

  localparam int DEF_PORTS          = 4;
  localparam int DEF_PCIE_ADDR_W    = 64;
  localparam int DEF_RAM_SEL_W      = 2;
  localparam int DEF_RAM_ADDR_W     = 16;
  localparam int DEF_LEN_W          = 16;
  localparam int DEF_S_TAG_W        = 8;
  localparam int DEF_M_RAM_SEL_W    = m_sel_width(DEF_RAM_SEL_W, DEF_PORTS);
  localparam int DEF_M_TAG_W        = m_tag_width(DEF_S_TAG_W, DEF_PORTS);

  typedef struct packed {
    logic [DEF_PCIE_ADDR_W-1:0] addr;
    logic [DEF_M_RAM_SEL_W-1:0] sel;
    logic [DEF_RAM_ADDR_W-1:0]  ram_addr;
    logic [DEF_LEN_W-1:0]       len;
    logic [DEF_M_TAG_W-1:0]     tag;
  } desc_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational rotating-priority arbiter; search starts one past ptr_i.
module dma_rr_arbiter
  import dma_rd_desc_arb_pkg::*;
#(
  parameter int PORTS    = 4,
  parameter int CL_PORTS = cl_ports(PORTS)
) (
  input  logic [PORTS-1:0]    req_i,
  input  logic [CL_PORTS-1:0] ptr_i,
  input  logic                adv_i,
  output logic [PORTS-1:0]    grant_o,
  output logic [CL_PORTS-1:0] idx_o,
  output logic                valid_o,
  output logic [CL_PORTS-1:0] ptr_d_o
);

  always_comb begin
    int p;
    p       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      p = (int'(ptr_i) + k) % PORTS;
      if (!valid_o && req_i[p]) begin
        valid_o    = 1'b1;
        grant_o[p] = 1'b1;
        idx_o      = CL_PORTS'(p);
      end
    end
  end

  // The winner becomes the lowest priority for the next search.
  assign ptr_d_o = adv_i ? idx_o : ptr_i;

endmodule

// File: rtl/dma_rd_desc_arb.sv
// Merges PORTS read-descriptor streams into one, tagging each with its source
// index, and steers returned status back. DMA_RD_DESC_ARB_STATUS_REG_EN registers the status path.
module dma_rd_desc_arb
  import dma_rd_desc_arb_pkg::*;
#(
  parameter int PORTS           = 4,
  parameter int CL_PORTS        = cl_ports(PORTS),
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int RAM_SEL_WIDTH   = 2,
  parameter int M_RAM_SEL_WIDTH = RAM_SEL_WIDTH + CL_PORTS,
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int S_TAG_WIDTH     = 8,
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,

  input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]     s_axis_read_desc_pcie_addr,
  input  logic [PORTS*RAM_SEL_WIDTH-1:0]       s_axis_read_desc_ram_sel,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0]      s_axis_read_desc_ram_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_read_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]         s_axis_read_desc_tag,
  input  logic [PORTS-1:0]                     s_axis_read_desc_valid,
  output logic [PORTS-1:0]                     s_axis_read_desc_ready,

  output logic [PCIE_ADDR_WIDTH-1:0]           m_axis_read_desc_pcie_addr,
  output logic [M_RAM_SEL_WIDTH-1:0]           m_axis_read_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]            m_axis_read_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]                 m_axis_read_desc_len,
  output logic [M_TAG_WIDTH-1:0]               m_axis_read_desc_tag,
  output logic                                 m_axis_read_desc_valid,
  input  logic                                 m_axis_read_desc_ready,

  input  logic [M_TAG_WIDTH-1:0]               s_axis_read_desc_status_tag,
  input  logic                                 s_axis_read_desc_status_valid,
  output logic [PORTS*S_TAG_WIDTH-1:0]         m_axis_read_desc_status_tag,
  output logic [PORTS-1:0]                     m_axis_read_desc_status_valid,
  output logic                                 status_drop
);

  localparam int NDEC = 1 << CL_PORTS;

  typedef struct packed {
    logic [PCIE_ADDR_WIDTH-1:0] addr;
    logic [M_RAM_SEL_WIDTH-1:0] sel;
    logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
    logic [LEN_WIDTH-1:0]       len;
    logic [M_TAG_WIDTH-1:0]     tag;
  } m_desc_t;

  logic [CL_PORTS-1:0] rr_q, rr_d, arb_idx;
  logic [PORTS-1:0]    arb_grant;
  logic                arb_vld, load, accept;
  logic                m_valid_q;
  m_desc_t             desc_q, desc_d;

  // Sources see no ready while reset is held, even though grant is combinational.
  assign load                   = ~m_valid_q | m_axis_read_desc_ready;
  assign accept                 = arb_vld & load & rst_n;
  assign s_axis_read_desc_ready = arb_grant & {PORTS{load & rst_n}};

  dma_rr_arbiter #(
    .PORTS    (PORTS),
    .CL_PORTS (CL_PORTS)
  ) u_arb (
    .req_i   (s_axis_read_desc_valid),
    .ptr_i   (rr_q),
    .adv_i   (accept),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_vld),
    .ptr_d_o (rr_d)
  );

  always_comb begin
    desc_d = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (arb_grant[i]) begin
        desc_d.addr     = s_axis_read_desc_pcie_addr[i*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
        desc_d.sel      = {arb_idx, s_axis_read_desc_ram_sel[i*RAM_SEL_WIDTH +: RAM_SEL_WIDTH]};
        desc_d.ram_addr = s_axis_read_desc_ram_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        desc_d.len      = s_axis_read_desc_len[i*LEN_WIDTH +: LEN_WIDTH];
        desc_d.tag      = {arb_idx, s_axis_read_desc_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= CL_PORTS'(PORTS - 1);
      m_valid_q <= 1'b0;
      desc_q    <= '0;
    end else begin
      rr_q <= rr_d;
      if (accept) begin
        m_valid_q <= 1'b1;
        desc_q    <= desc_d;
      end else if (m_axis_read_desc_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_read_desc_valid     = m_valid_q;
  assign m_axis_read_desc_pcie_addr = desc_q.addr;
  assign m_axis_read_desc_ram_sel   = desc_q.sel;
  assign m_axis_read_desc_ram_addr  = desc_q.ram_addr;
  assign m_axis_read_desc_len       = desc_q.len;
  assign m_axis_read_desc_tag       = desc_q.tag;

  logic [CL_PORTS-1:0]          st_idx;
  logic [NDEC-1:0]              st_dec;
  logic [PORTS-1:0]             st_hit;
  logic                         st_drop;
  logic [PORTS*S_TAG_WIDTH-1:0] st_tag;

  assign st_idx = s_axis_read_desc_status_tag[M_TAG_WIDTH-1 -: CL_PORTS];

  // Decode over the full index space; anything above PORTS-1 is a drop.
  always_comb begin
    st_dec         = '0;
    st_dec[st_idx] = s_axis_read_desc_status_valid;
    st_hit         = st_dec[PORTS-1:0];
    st_drop        = |(st_dec >> PORTS);
    st_tag         = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (st_hit[i]) st_tag[i*S_TAG_WIDTH +: S_TAG_WIDTH] = s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
    end
  end

`ifdef DMA_RD_DESC_ARB_STATUS_REG_EN
  logic [PORTS-1:0]             st_vld_q;
  logic [PORTS*S_TAG_WIDTH-1:0] st_tag_q;
  logic                         st_drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld_q  <= '0;
      st_tag_q  <= '0;
      st_drop_q <= 1'b0;
    end else begin
      st_vld_q  <= st_hit;
      st_tag_q  <= st_tag;
      st_drop_q <= st_drop;
    end
  end

  assign m_axis_read_desc_status_valid = st_vld_q;
  assign m_axis_read_desc_status_tag   = st_tag_q;
  assign status_drop                   = st_drop_q;
`else
  assign m_axis_read_desc_status_valid = st_hit & {PORTS{rst_n}};
  assign m_axis_read_desc_status_tag   = st_tag & {(PORTS*S_TAG_WIDTH){rst_n}};
  assign status_drop                   = st_drop & rst_n;
`endif

endmodule

// File: tb/tb_dma_rd_desc_arb.sv
// Randomized bench for dma_rd_desc_arb with a queue-free rotating-priority reference model.
module tb_dma_rd_desc_arb;

  localparam int P   = 4;
  localparam int AW  = 64;
  localparam int SW  = 2;
  localparam int RW  = 16;
  localparam int LW  = 16;
  localparam int TW  = 8;
  localparam int MSW = 4;
  localparam int MTW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [P*AW-1:0] s_addr_f;
  logic [P*SW-1:0] s_sel_f;
  logic [P*RW-1:0] s_ram_f;
  logic [P*LW-1:0] s_len_f;
  logic [P*TW-1:0] s_tag_f;
  logic [P-1:0]    src_v, s_ready;
  logic [AW-1:0]   m_addr;
  logic [MSW-1:0]  m_sel;
  logic [RW-1:0]   m_ram;
  logic [LW-1:0]   m_len;
  logic [MTW-1:0]  m_tag;
  logic            m_valid, mrdy;
  logic [MTW-1:0]  st_tag_in;
  logic            st_v_in;
  logic [P*TW-1:0] m_st_tag;
  logic [P-1:0]    m_st_v;
  logic            drop;

  // Second instance with a non-power-of-two port count exercises status drops.
  logic [3*AW-1:0] z_addr3 = '0;
  logic [3*SW-1:0] z_sel3  = '0;
  logic [3*RW-1:0] z_ram3  = '0;
  logic [3*LW-1:0] z_len3  = '0;
  logic [3*TW-1:0] z_tag3  = '0;
  logic [2:0]      z_v3    = '0;
  logic            one3    = 1'b1;
  logic [2:0]      s_ready3;
  logic [AW-1:0]   m_addr3;
  logic [MSW-1:0]  m_sel3;
  logic [RW-1:0]   m_ram3;
  logic [LW-1:0]   m_len3;
  logic [MTW-1:0]  m_tag3;
  logic            m_valid3;
  logic [3*TW-1:0] m_st_tag3;
  logic [2:0]      m_st_v3;
  logic            drop3;

  logic [AW-1:0] src_addr[P];
  logic [SW-1:0] src_sel[P];
  logic [RW-1:0] src_ram[P];
  logic [LW-1:0] src_len[P];
  logic [TW-1:0] src_tag[P];

  always_comb begin
    for (int i = 0; i < P; i++) begin
      s_addr_f[i*AW +: AW] = src_addr[i];
      s_sel_f[i*SW +: SW]  = src_sel[i];
      s_ram_f[i*RW +: RW]  = src_ram[i];
      s_len_f[i*LW +: LW]  = src_len[i];
      s_tag_f[i*TW +: TW]  = src_tag[i];
    end
  end

  dma_rd_desc_arb u_dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .s_axis_read_desc_pcie_addr    (s_addr_f),
    .s_axis_read_desc_ram_sel      (s_sel_f),
    .s_axis_read_desc_ram_addr     (s_ram_f),
    .s_axis_read_desc_len          (s_len_f),
    .s_axis_read_desc_tag          (s_tag_f),
    .s_axis_read_desc_valid        (src_v),
    .s_axis_read_desc_ready        (s_ready),
    .m_axis_read_desc_pcie_addr    (m_addr),
    .m_axis_read_desc_ram_sel      (m_sel),
    .m_axis_read_desc_ram_addr     (m_ram),
    .m_axis_read_desc_len          (m_len),
    .m_axis_read_desc_tag          (m_tag),
    .m_axis_read_desc_valid        (m_valid),
    .m_axis_read_desc_ready        (mrdy),
    .s_axis_read_desc_status_tag   (st_tag_in),
    .s_axis_read_desc_status_valid (st_v_in),
    .m_axis_read_desc_status_tag   (m_st_tag),
    .m_axis_read_desc_status_valid (m_st_v),
    .status_drop                   (drop)
  );

  dma_rd_desc_arb #(.PORTS(3)) u_dut3 (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .s_axis_read_desc_pcie_addr    (z_addr3),
    .s_axis_read_desc_ram_sel      (z_sel3),
    .s_axis_read_desc_ram_addr     (z_ram3),
    .s_axis_read_desc_len          (z_len3),
    .s_axis_read_desc_tag          (z_tag3),
    .s_axis_read_desc_valid        (z_v3),
    .s_axis_read_desc_ready        (s_ready3),
    .m_axis_read_desc_pcie_addr    (m_addr3),
    .m_axis_read_desc_ram_sel      (m_sel3),
    .m_axis_read_desc_ram_addr     (m_ram3),
    .m_axis_read_desc_len          (m_len3),
    .m_axis_read_desc_tag          (m_tag3),
    .m_axis_read_desc_valid        (m_valid3),
    .m_axis_read_desc_ready        (one3),
    .s_axis_read_desc_status_tag   (st_tag_in),
    .s_axis_read_desc_status_valid (st_v_in),
    .m_axis_read_desc_status_tag   (m_st_tag3),
    .m_axis_read_desc_status_valid (m_st_v3),
    .status_drop                   (drop3)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference state: last granted port, and what the output register should hold.
  int            last;
  bit            mv;
  logic [AW-1:0] e_addr;
  logic [MSW-1:0] e_sel;
  logic [RW-1:0] e_ram;
  logic [LW-1:0] e_len;
  logic [MTW-1:0] e_tag;
  int            acc;
  logic [P-1:0]  obs_v;
  logic          obs_drop3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic arm(input int i);
    src_addr[i] = {$urandom, $urandom};
    src_sel[i]  = SW'($urandom);
    src_ram[i]  = RW'($urandom);
    src_len[i]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
    src_tag[i]  = TW'($urandom);
    src_v[i]    = 1'b1;
  endtask

  function automatic int pick(input int from, input logic [P-1:0] v);
    for (int k = 1; k <= P; k++)
      if (v[(from + k) % P]) return (from + k) % P;
    return -1;
  endfunction

  task automatic rnd_status();
    st_v_in   = 1'($urandom_range(0, 1));
    st_tag_in = MTW'($urandom);
  endtask

  task automatic check_status();
    int idx;
    idx = int'(st_tag_in[MTW-1 -: 2]);
    if (st_v_in) begin
      chk("st_v", 64'(m_st_v), 64'(1) << idx);
      chk("st_tag", 64'(m_st_tag[idx*TW +: TW]), 64'(st_tag_in[TW-1:0]));
      chk("st_drop", 64'(drop), 0);
      if (idx < 3) begin
        chk("st3_v", 64'(m_st_v3), 64'(1) << idx);
        chk("st3_tag", 64'(m_st_tag3[idx*TW +: TW]), 64'(st_tag_in[TW-1:0]));
        chk("st3_drop", 64'(drop3), 0);
      end else begin
        chk("st3_v", 64'(m_st_v3), 0);
        chk("st3_drop", 64'(drop3), 1);
      end
    end else begin
      chk("st_v_idle", 64'(m_st_v), 0);
      chk("st_drop_idle", 64'(drop), 0);
      chk("st3_v_idle", 64'(m_st_v3), 0);
      chk("st3_drop_idle", 64'(drop3), 0);
    end
    obs_v     = m_st_v;
    obs_drop3 = drop3;
  endtask

  // One clock: inputs were set just after a falling edge.
  task automatic step();
    int g;
    bit load;
    #1;
    load = !mv || mrdy;
    g    = pick(last, src_v);
    chk("s_ready", 64'(s_ready), (load && g >= 0) ? (64'(1) << g) : 64'(0));
`ifndef DMA_RD_DESC_ARB_STATUS_REG_EN
    check_status();
`endif
    @(posedge clk);
    acc = -1;
    if (load && g >= 0) begin
      mv     = 1'b1;
      e_addr = src_addr[g];
      e_sel  = {2'(g), src_sel[g]};
      e_ram  = src_ram[g];
      e_len  = src_len[g];
      e_tag  = {2'(g), src_tag[g]};
      last   = g;
      acc    = g;
    end else if (mrdy) begin
      mv = 1'b0;
    end
    #1;
    chk("m_valid", 64'(m_valid), 64'(mv));
    if (mv) begin
      chk("m_addr", m_addr, e_addr);
      chk("m_sel", 64'(m_sel), 64'(e_sel));
      chk("m_ram", 64'(m_ram), 64'(e_ram));
      chk("m_len", 64'(m_len), 64'(e_len));
      chk("m_tag", 64'(m_tag), 64'(e_tag));
    end
`ifdef DMA_RD_DESC_ARB_STATUS_REG_EN
    check_status();
`endif
    @(negedge clk);
    if (acc >= 0) src_v[acc] = 1'b0;
  endtask

  initial begin
    int cnt0, cnt1;
    src_v = '0; mrdy = 1'b0; st_v_in = 1'b0; st_tag_in = '0;
    for (int i = 0; i < P; i++) arm(i);
    mv = 1'b0; last = P - 1; acc = -1;
    obs_v = '0; obs_drop3 = 1'b0;

    // Reset: everything quiet even with sources and a status strobe asserted.
    repeat (2) @(negedge clk);
    st_v_in = 1'b1; st_tag_in = 10'h3A7;
    #1;
    chk("rst_ready", 64'(s_ready), 0);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_tag", 64'(m_tag), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_st_v", 64'(m_st_v), 0);
    chk("rst_st_tag", 64'(m_st_tag), 0);
    chk("rst_drop3", 64'(drop3), 0);
    @(negedge clk);
    rst_n = 1'b1; st_v_in = 1'b0;

    // Fairness: all ports busy, one grant per cycle in order 0,1,2,3,...
    mrdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rnd_status();
      step();
      chk("fair_grant", 64'(acc), 64'(k % P));
      if (acc >= 0) arm(acc);
    end

    // Single port: port 2 with tag 0x15, ram_sel 1.
    src_v = '0; st_v_in = 1'b0;
    step();
    arm(2); src_tag[2] = 8'h15; src_sel[2] = 2'd1;
    step();
    chk("sp_tag", 64'(m_tag), 64'h215);
    chk("sp_sel", 64'(m_sel), 64'b1001);
    chk("sp_len", 64'(m_len), 64'(src_len[2]));

    // Backpressure: held output while two ports wait, then each drains once.
    mrdy = 1'b0; arm(0); arm(1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ready", 64'(s_ready), 0);
    end
    mrdy = 1'b1; cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (acc == 0) cnt0++;
      if (acc == 1) cnt1++;
    end
    chk("bp_cnt0", 64'(cnt0), 1);
    chk("bp_cnt1", 64'(cnt1), 1);

    // Status routing 0x3A7: port 3 on the 4-port block, dropped on the 3-port one.
    st_v_in = 1'b1; st_tag_in = 10'h3A7;
    step();
    chk("st_3a7_v", 64'(obs_v), 64'b1000);
    chk("st_3a7_drop3", 64'(obs_drop3), 1);
    st_v_in = 1'b0;
    step();
    chk("st_drop_once", 64'(obs_drop3), 0);

    // Reset while the output is stalled.
    mrdy = 1'b0; src_v = '0; arm(3);
    step();
    step();
    for (int i = 0; i < P; i++) arm(i);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_valid", 64'(m_valid), 0);
    chk("rst_mid_ready", 64'(s_ready), 0);
    mv = 1'b0; last = P - 1;
    @(negedge clk);
    rst_n = 1'b1; mrdy = 1'b1;
    step();
    chk("post_rst_grant", 64'(acc), 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      mrdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < P; i++)
        if (!src_v[i] && $urandom_range(0, 1) == 1) arm(i);
      rnd_status();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
